// File: rtl/mem_bus_pkg.sv
// Shared types for the memory bus front-end: FSM states, grant encoding and
// the wait-state counter width.
package mem_bus_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_VID = 1'b1
  } gnt_t;

endpackage

// File: rtl/mem_bus_arb.sv
// Two-way CPU/video arbiter. req[0] is the CPU, req[1] is video; the pointer
// names the channel that wins the next tie in round-robin mode.
module mem_bus_arb
  import mem_bus_pkg::*;
#(
  parameter bit VID_PRIO = 1'b1
) (
  input  logic       clk,
  input  logic       locked,
  input  logic [1:0] req,
  input  logic       advance,
  output gnt_t       gnt
);

  gnt_t rr_ptr;

  always_comb begin
    gnt = GNT_CPU;
    if (req == 2'b11) begin
      gnt = VID_PRIO ? GNT_VID : rr_ptr;
    end else if (req[1]) begin
      gnt = GNT_VID;
    end
  end

  // Every grant moves the pointer away from the winner, so a lone access
  // also counts as that channel's turn.
  always_ff @(posedge clk) begin
    if (!locked) begin
      rr_ptr <= GNT_CPU;
    end else if (advance) begin
      rr_ptr <= (gnt == GNT_CPU) ? GNT_VID : GNT_CPU;
    end
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory front-end: serialises CPU and video accesses onto one synchronous
// memory port with WAIT programmable wait states.
//
// state | meaning
// IDLE  | sample requests, grant one, drive memory address/data/strobe
// ACC   | wait-state countdown; write strobe dropped after first cycle
// DATA  | memory read data valid, capture into granted channel
// RESP  | ready/ack pulse high, no new grant
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned WAIT     = 1,
  parameter bit          VID_PRIO = 1'b1
) (
  input  logic              clk,
  input  logic              locked,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_wr,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              vid_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  if (WAIT > (2 ** CNT_W) - 1) begin : g_bad_wait
    $error("mem_bus_ctrl: WAIT=%0d does not fit the %0d-bit wait counter", WAIT, CNT_W);
  end

  localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT);

  state_t           state;
  gnt_t             gnt;
  gnt_t             gnt_q;
  logic             wr_q;
  logic [CNT_W-1:0] cnt;
  logic             advance;

  assign advance = (state == IDLE) && (cpu_req || vid_req);

  mem_bus_arb #(
    .VID_PRIO (VID_PRIO)
  ) u_arb (
    .clk     (clk),
    .locked  (locked),
    .req     ({vid_req, cpu_req}),
    .advance (advance),
    .gnt     (gnt)
  );

  always_ff @(posedge clk) begin
    if (!locked) begin
      state     <= IDLE;
      gnt_q     <= GNT_CPU;
      wr_q      <= 1'b0;
      cnt       <= '0;
      cpu_rdata <= '0;
      cpu_ready <= 1'b0;
      vid_rdata <= '0;
      vid_ack   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
    end else begin
      cpu_ready <= 1'b0;
      vid_ack   <= 1'b0;
      case (state)
        IDLE: begin
          if (advance) begin
            gnt_q <= gnt;
            cnt   <= WAIT_CNT;
            state <= ACC;
            if (gnt == GNT_VID) begin
              mem_addr <= vid_addr;
              mem_we   <= 1'b0;
              wr_q     <= 1'b0;
            end else begin
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_wdata;
              mem_we    <= cpu_wr;
              wr_q      <= cpu_wr;
            end
          end
        end
        ACC: begin
          mem_we <= 1'b0;
          if (cnt == '0) begin
            state <= DATA;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DATA: begin
          if (gnt_q == GNT_VID) begin
            vid_rdata <= mem_rdata;
            vid_ack   <= 1'b1;
          end else begin
            // Writes still pulse ready but leave the last read value intact.
            if (!wr_q) begin
              cpu_rdata <= mem_rdata;
            end
            cpu_ready <= 1'b1;
          end
          state <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: four instances with different WAIT and
// VID_PRIO settings, each with its own one-cycle-latency memory model.
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  int          cyc = 0;
  logic        mem_clr;
  int          total = 0;
  int          bad = 0;

  logic        locked    [4];
  logic        cpu_req   [4];
  logic [15:0] cpu_addr  [4];
  logic [7:0]  cpu_wdata [4];
  logic        cpu_wr    [4];
  logic [7:0]  cpu_rdata [4];
  logic        cpu_ready [4];
  logic        vid_req   [4];
  logic [15:0] vid_addr  [4];
  logic [7:0]  vid_rdata [4];
  logic        vid_ack   [4];
  logic [15:0] mem_addr  [4];
  logic [7:0]  mem_wdata [4];
  logic        mem_we    [4];
  logic [7:0]  mem_rdata [4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] init_val(input logic [7:0] a);
    case (a)
      8'h34:   return 8'hA5;
      8'h10:   return 8'h5A;
      8'h20:   return 8'hC3;
      default: return ~a;
    endcase
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_inst
    logic [7:0]   mem_q [256];
    logic [255:0] wr_flag;

    mem_bus_ctrl #(
      .ADDR_W   (16),
      .DATA_W   (8),
      .WAIT     ((g == 0) ? 1 : (g == 1) ? 0 : (g == 2) ? 3 : 15),
      .VID_PRIO ((g == 0 || g == 2) ? 1'b1 : 1'b0)
    ) u_dut (
      .clk       (clk),
      .locked    (locked[g]),
      .cpu_req   (cpu_req[g]),
      .cpu_addr  (cpu_addr[g]),
      .cpu_wdata (cpu_wdata[g]),
      .cpu_wr    (cpu_wr[g]),
      .cpu_rdata (cpu_rdata[g]),
      .cpu_ready (cpu_ready[g]),
      .vid_req   (vid_req[g]),
      .vid_addr  (vid_addr[g]),
      .vid_rdata (vid_rdata[g]),
      .vid_ack   (vid_ack[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_we    (mem_we[g]),
      .mem_rdata (mem_rdata[g])
    );

    always @(posedge clk) begin
      if (mem_clr) begin
        wr_flag <= '0;
      end else if (mem_we[g]) begin
        mem_q[mem_addr[g][7:0]]   <= mem_wdata[g];
        wr_flag[mem_addr[g][7:0]] <= 1'b1;
      end
      mem_rdata[g] <= wr_flag[mem_addr[g][7:0]] ? mem_q[mem_addr[g][7:0]]
                                                : init_val(mem_addr[g][7:0]);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One access on instance i; latency is counted in edges from the sampling
  // edge to the edge that raises ready/ack.
  task automatic access(input int i, input bit vid, input bit wr,
                        input logic [15:0] a, input logic [7:0] d,
                        input int exp_lat, input logic [7:0] exp_rd, input string tag);
    int e, lat, we_cnt;
    bit seen;
    lat = -1;
    we_cnt = 0;
    seen = 0;
    @(negedge clk);
    if (vid) begin
      vid_req[i] = 1'b1;
      vid_addr[i] = a;
    end else begin
      cpu_req[i] = 1'b1;
      cpu_addr[i] = a;
      cpu_wdata[i] = d;
      cpu_wr[i] = wr;
    end
    e = cyc + 1;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (mem_we[i]) we_cnt++;
      if (vid ? vid_ack[i] : cpu_ready[i]) begin
        seen = 1;
        lat = cyc - e;
      end
    end
    cpu_req[i] = 1'b0;
    cpu_wr[i] = 1'b0;
    vid_req[i] = 1'b0;
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_rdata"}, vid ? vid_rdata[i] : cpu_rdata[i], exp_rd);
    chk({tag, "_we_cycles"}, we_cnt, (wr && !vid) ? 1 : 0);
    @(negedge clk);
    chk({tag, "_pulse_width"}, vid ? vid_ack[i] : cpu_ready[i], 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, tv, tc, n, code, quiet;
    mem_clr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      locked[i] = 1'b0;
      cpu_req[i] = 1'b0;
      cpu_addr[i] = '0;
      cpu_wdata[i] = '0;
      cpu_wr[i] = 1'b0;
      vid_req[i] = 1'b0;
      vid_addr[i] = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_cpu_ready", cpu_ready[0], 1'b0);
    chk("rst_vid_ack", vid_ack[0], 1'b0);
    chk("rst_mem_we", mem_we[0], 1'b0);
    chk("rst_mem_addr", mem_addr[0], 16'h0000);
    chk("rst_cpu_rdata", cpu_rdata[0], 8'h00);
    mem_clr = 1'b0;
    for (int i = 0; i < 4; i++) locked[i] = 1'b1;

    // CPU read, WAIT=1
    access(0, 1'b0, 1'b0, 16'h1234, 8'h00, 3, 8'hA5, "t1_cpu_rd");
    access(0, 1'b1, 1'b0, 16'h0010, 8'h00, 3, 8'h5A, "t1_vid_rd");
    chk("t1_cpu_rdata_hold", cpu_rdata[0], 8'hA5);

    // Write then read back, WAIT=0; the write must not disturb cpu_rdata
    access(1, 1'b0, 1'b0, 16'h1234, 8'h00, 2, 8'hA5, "t2_rd0");
    access(1, 1'b0, 1'b1, 16'h0040, 8'h3C, 2, 8'hA5, "t2_wr");
    access(1, 1'b0, 1'b0, 16'h0040, 8'h00, 2, 8'h3C, "t2_rd");

    // Collision with video priority, WAIT=1
    tv = -1;
    tc = -1;
    @(negedge clk);
    cpu_req[0] = 1'b1;
    cpu_addr[0] = 16'h0020;
    cpu_wr[0] = 1'b0;
    vid_req[0] = 1'b1;
    vid_addr[0] = 16'h0010;
    e = cyc + 1;
    for (int k = 0; k < 40 && (tv < 0 || tc < 0); k++) begin
      @(negedge clk);
      if (vid_ack[0] && tv < 0) begin
        tv = cyc - e;
        vid_req[0] = 1'b0;
      end
      if (cpu_ready[0] && tc < 0) begin
        tc = cyc - e;
        cpu_req[0] = 1'b0;
      end
    end
    cpu_req[0] = 1'b0;
    vid_req[0] = 1'b0;
    chk("t3_vid_first_lat", tv, 3);
    chk("t3_cpu_second_lat", tc, 8);
    chk("t3_vid_rdata", vid_rdata[0], 8'h5A);
    chk("t3_cpu_rdata", cpu_rdata[0], 8'hC3);

    // Round-robin from a fresh reset, both requests held, WAIT=0
    @(negedge clk);
    locked[1] = 1'b0;
    @(negedge clk);
    locked[1] = 1'b1;
    cpu_req[1] = 1'b1;
    cpu_addr[1] = 16'h0020;
    cpu_wr[1] = 1'b0;
    vid_req[1] = 1'b1;
    vid_addr[1] = 16'h0010;
    n = 0;
    code = 0;
    for (int k = 0; k < 60 && n < 4; k++) begin
      @(negedge clk);
      if (cpu_ready[1]) begin
        code = (code << 1);
        n++;
      end
      if (vid_ack[1]) begin
        code = (code << 1) | 1;
        n++;
      end
    end
    cpu_req[1] = 1'b0;
    vid_req[1] = 1'b0;
    chk("t4_grant_count", n, 4);
    chk("t4_grant_order", code, 4'b0101);
    chk("t4_cpu_rdata", cpu_rdata[1], 8'hC3);
    chk("t4_vid_rdata", vid_rdata[1], 8'h5A);

    // Reset during ACC, WAIT=3; the strobed write must survive
    access(2, 1'b0, 1'b0, 16'h1234, 8'h00, 5, 8'hA5, "t5_pre_rd");
    @(negedge clk);
    cpu_req[2] = 1'b1;
    cpu_addr[2] = 16'h0055;
    cpu_wdata[2] = 8'h77;
    cpu_wr[2] = 1'b1;
    @(negedge clk);
    chk("t5_we_strobe", mem_we[2], 1'b1);
    @(negedge clk);
    locked[2] = 1'b0;
    cpu_req[2] = 1'b0;
    cpu_wr[2] = 1'b0;
    @(negedge clk);
    locked[2] = 1'b1;
    chk("t5_rst_cpu_ready", cpu_ready[2], 1'b0);
    chk("t5_rst_vid_ack", vid_ack[2], 1'b0);
    chk("t5_rst_mem_we", mem_we[2], 1'b0);
    chk("t5_rst_mem_addr", mem_addr[2], 16'h0000);
    chk("t5_rst_mem_wdata", mem_wdata[2], 8'h00);
    chk("t5_rst_cpu_rdata", cpu_rdata[2], 8'h00);
    chk("t5_rst_vid_rdata", vid_rdata[2], 8'h00);
    quiet = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (cpu_ready[2]) quiet++;
    end
    chk("t5_no_ready_after_drop", quiet, 0);
    access(2, 1'b0, 1'b0, 16'h0055, 8'h00, 5, 8'h77, "t5_reissue_rd");

    // Maximum wait states
    access(3, 1'b0, 1'b0, 16'h0020, 8'h00, 17, 8'hC3, "t6_cpu_rd");
    access(3, 1'b1, 1'b0, 16'h0010, 8'h00, 17, 8'h5A, "t6_vid_rd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_ctrl.md
# mem_bus_ctrl

Parametrised memory front-end between the `processor` bus and the on-chip synchronous `memory`. It replaces the tied-high `m_ready` with a real wait-state handshake and adds a second read-only channel for video fetch, arbitrated against the CPU. Each access is serialised onto one memory port with a programmable number of wait states.

## Interface
Parameters:
- `ADDR_W`, 16, address width on all ports
- `DATA_W`, 8, data width on all ports
- `WAIT`, 1, extra wait cycles per access (0..15)
- `VID_PRIO`, 1, 1 = video wins ties; 0 = round-robin

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `locked`  in  1  synchronous active-low reset (0 = held in reset)
- `cpu_req`  in  1  CPU access request; held until `cpu_ready`
- `cpu_addr`  in  ADDR_W  CPU address
- `cpu_wdata`  in  DATA_W  CPU write data
- `cpu_wr`  in  1  1 = write, 0 = read
- `cpu_rdata`  out  DATA_W  read data, valid while `cpu_ready`=1
- `cpu_ready`  out  1  one-cycle completion pulse (becomes the processor's `m_ready`)
- `vid_req`  in  1  video read request; held until `vid_ack`
- `vid_addr`  in  ADDR_W  video address
- `vid_rdata`  out  DATA_W  video read data, valid while `vid_ack`=1
- `vid_ack`  out  1  one-cycle completion pulse
- `mem_addr`  out  ADDR_W  memory address (registered)
- `mem_wdata`  out  DATA_W  memory write data (registered)
- `mem_we`  out  1  memory write strobe (registered)
- `mem_rdata`  in  DATA_W  memory read data, one-cycle synchronous latency

## Operation
- FSM states:
  - IDLE: sample requests, grant one, and load `mem_addr`/`mem_wdata`/`mem_we`. Set `cnt` = WAIT and go to ACC.
  - ACC: `mem_we` is forced to 0 after the first ACC cycle. If `cnt`==0, go to DATA; otherwise decrement `cnt`.
  - DATA: `mem_rdata` is valid. Capture it into the granted channel's rdata register, set that channel's ready/ack, and go to RESP.
  - RESP: ready/ack is high for this cycle only. No grant is made. Go to IDLE.
- Arbitration applies when both requests are high in IDLE:
  - `VID_PRIO`=1: video is granted.
  - `VID_PRIO`=0: grant the channel not granted last; after reset, the CPU is first.
- Video accesses are always reads (`mem_we`=0).
- CPU writes complete with the same latency as reads. `cpu_rdata` is unchanged by writes.
- A request still high in RESP is ignored; it is re-sampled in IDLE as a new access.
- `cpu_rdata`/`vid_rdata` hold their last captured value until the next capture on that channel.
- `cnt` is 4 bits, so WAIT > 15 is illegal. Add an elaboration-time check.

## Timing
- Request sampled at edge E (IDLE). `mem_addr` and `mem_we` are valid after E.
- ACC occupies edges E+1 .. E+WAIT+1. DATA captures at edge E+WAIT+2.
- ready/ack is high in the cycle after edge E+WAIT+2, for exactly one cycle.
- Throughput: one access per WAIT+4 cycles.
- `mem_we` is high for exactly one cycle, the cycle after E.
- Reset (`locked`=0 at any edge), including mid-access:
  - next state is IDLE;
  - `cpu_ready`=0, `vid_ack`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0;
  - `cpu_rdata`=0, `vid_rdata`=0;
  - round-robin pointer points at CPU.
- An in-flight access is dropped without a ready/ack. A write already strobed stays written.
- Outputs are all registered, with no combinational path from inputs to outputs.

## Structure
- Package `mem_bus_pkg`:
  - state enum (IDLE, ACC, DATA, RESP);
  - grant encoding (GNT_CPU=0, GNT_VID=1);
  - `CNT_W`=4.
- Sub-module `mem_bus_arb`: two-input arbiter taking `VID_PRIO`, `req[1:0]`, a last-grant register and an `advance` strobe; it outputs `gnt`.
- The FSM, counter and data capture stay in `mem_bus_ctrl`.

## Test plan
1. **CPU read.** WAIT=1, memory preloaded with 0xA5 at 0x1234. `cpu_req`=1, read 0x1234 sampled at edge 10 → `cpu_ready`=1 only in the cycle after edge 13, with `cpu_rdata`=0xA5.
2. **CPU write then read.** WAIT=0: write 0x3C to 0x0040 → `mem_we`=1 for exactly one cycle and `cpu_ready` after E+2. A following read of 0x0040 returns 0x3C.
3. **Collision, video priority.** `VID_PRIO`=1, both requests raised at the same edge → video served first (`vid_ack`), then the CPU. The CPU's `cpu_ready` comes WAIT+4 cycles after `vid_ack`.
4. **Round-robin.** `VID_PRIO`=0, both requests held continuously for 4 accesses → grant order CPU, VID, CPU, VID.
5. **Reset mid-access.** WAIT=3, `locked`=0 for one edge during ACC → no `cpu_ready`; all outputs are 0 the next cycle. The FSM returns to IDLE and a re-issued request completes normally.
6. **Maximum wait states.** WAIT=15 → read latency is exactly 17 edges to `cpu_ready`, and `cpu_ready` never exceeds one cycle wide.
